line_follower_pd: RTL and testbench

- Parametrised, clocked successor to the team's combinational white-line follower.
- Takes NCH packed ADC reflectance samples, qualified by adc_valid, from the on-board ADC controller.
- Computes a registered PD steering correction with clamped motor speeds.
- Debounces node (junction) detection, counts nodes, and runs a lost-line search with timeout.
- Drives the left/right motor PWM/direction block.

---
 rtl/lf_pkg.sv | 27 ++
 rtl/lf_error_calc.sv | 48 ++++
 rtl/line_follower_pd.sv | 198 +++++++++++++++++++
 tb/tb_line_follower_pd.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lf_pkg.sv
// Shared types and constants for the line follower and the motor block.
package lf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FOLLOW = 2'd1,
        ST_LOST   = 2'd2,
        ST_STOP   = 2'd3
    } lf_state_t;

    localparam int DEF_BASE_SPD  = 11000;
    localparam int DEF_MAX_SPD   = 16383;
    localparam int DEF_DARK_TH   = 1600;
    localparam int DEF_BRIGHT_TH = 600;

    function automatic int clamp_spd(input int v, input int hi);
        int r;
        r = v;
        if (v < 0) begin
            r = 0;
        end else if (v > hi) begin
            r = hi;
        end
        return r;
    endfunction

endpackage

// File: rtl/lf_error_calc.sv
// Stage-1 combinational left/right reflectance difference and all-dark/all-bright flags.
// Zero latency; purely combinational, no flow control.
module lf_error_calc #(
    parameter int NCH       = 3,
    parameter int ADC_W     = 12,
    parameter int DARK_TH   = 1600,
    parameter int BRIGHT_TH = 600,
    parameter int EW        = ADC_W + $clog2(NCH) + 1
) (
    input  logic [NCH*ADC_W-1:0] adc_data,
    output logic signed [EW-1:0] err,
    output logic                 all_dark,
    output logic                 all_bright
);

    localparam logic [ADC_W-1:0] DARK_C   = ADC_W'(DARK_TH);
    localparam logic [ADC_W-1:0] BRIGHT_C = ADC_W'(BRIGHT_TH);

    logic [EW-1:0]    sum_l;
    logic [EW-1:0]    sum_r;
    logic [ADC_W-1:0] ch;

    // With odd NCH the centre channel falls in neither half.
    always_comb begin
        sum_l      = '0;
        sum_r      = '0;
        ch         = '0;
        all_dark   = 1'b1;
        all_bright = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            ch = adc_data[i*ADC_W +: ADC_W];
            if (i < NCH/2) begin
                sum_l = sum_l + EW'(ch);
            end
            if (i >= NCH - NCH/2) begin
                sum_r = sum_r + EW'(ch);
            end
            if (ch <= DARK_C) begin
                all_dark = 1'b0;
            end
            if (ch >= BRIGHT_C) begin
                all_bright = 1'b0;
            end
        end
        err = $signed(sum_l - sum_r);
    end

endmodule

// File: rtl/line_follower_pd.sv
// Two-stage PD line follower with node debounce, lost-line search and timeout stop.
// Outputs update 2 edges after adc_valid; accepts a sample every cycle, no backpressure.
module line_follower_pd
    import lf_pkg::*;
#(
    parameter int NCH       = 3,
    parameter int ADC_W     = 12,
    parameter int SPD_W     = 14,
    parameter int BASE_SPD  = DEF_BASE_SPD,
    parameter int MAX_SPD   = DEF_MAX_SPD,
    parameter int DARK_TH   = DEF_DARK_TH,
    parameter int BRIGHT_TH = DEF_BRIGHT_TH,
    parameter int KP_SH     = 0,
    parameter int KD_SH     = 0,
    parameter int NODE_CNT  = 4,
    parameter int LOST_TMO  = 50
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NCH*ADC_W-1:0] adc_data,
    input  logic                 adc_valid,
    output logic [SPD_W-1:0]     speed_l,
    output logic                 dir_l,
    output logic [SPD_W-1:0]     speed_r,
    output logic                 dir_r,
    output logic                 node_pulse,
    output logic [7:0]           node_cnt,
    output logic                 lost,
    output logic [1:0]           state_o
);

    localparam int EW = ADC_W + $clog2(NCH) + 1;
    localparam int IW = SPD_W + ADC_W + 3;
    localparam int DW = $clog2(NODE_CNT + 1);
    localparam int BW = $clog2(LOST_TMO + 1);
    localparam logic [DW-1:0]    NODE_C = DW'(NODE_CNT);
    localparam logic [BW-1:0]    TMO_C  = BW'(LOST_TMO);
    localparam logic [SPD_W-1:0] BASE_C = SPD_W'(BASE_SPD);

    logic signed [EW-1:0] c_err, s1_err, prev_err, prev_err_n;
    logic                 c_dark, c_bright, s1_vld, s1_dark, s1_bright;
    lf_state_t            state, state_n, cur;
    logic [DW-1:0]        dark_cnt, dark_n;
    logic [BW-1:0]        bright_cnt, bright_n;
    logic [SPD_W-1:0]     speed_l_n, speed_r_n, pd_l, pd_r;
    logic                 dir_l_n, dir_r_n, pulse_n, lost_n;
    logic [7:0]           node_cnt_n;
    logic signed [IW-1:0] err_x, prev_x, p_x, d_x, raw_l, raw_r;

    lf_error_calc #(
        .NCH       (NCH),
        .ADC_W     (ADC_W),
        .DARK_TH   (DARK_TH),
        .BRIGHT_TH (BRIGHT_TH),
        .EW        (EW)
    ) u_err (
        .adc_data   (adc_data),
        .err        (c_err),
        .all_dark   (c_dark),
        .all_bright (c_bright)
    );

    // Stage 1; dropping en discards the in-flight sample.
    always_ff @(posedge clk) begin
        if (!rst || !en) begin
            s1_vld    <= 1'b0;
            s1_err    <= '0;
            s1_dark   <= 1'b0;
            s1_bright <= 1'b0;
        end else begin
            s1_vld <= adc_valid;
            if (adc_valid) begin
                s1_err    <= c_err;
                s1_dark   <= c_dark;
                s1_bright <= c_bright;
            end
        end
    end

    always_comb begin
        err_x  = IW'(s1_err);
        prev_x = IW'(prev_err);
        p_x    = err_x >>> KP_SH;
        d_x    = (err_x - prev_x) >>> KD_SH;
        raw_l  = IW'(BASE_SPD) - p_x - d_x;
        raw_r  = IW'(BASE_SPD) + p_x + d_x;
        pd_l   = SPD_W'(clamp_spd(int'(raw_l), MAX_SPD));
        pd_r   = SPD_W'(clamp_spd(int'(raw_r), MAX_SPD));
    end

    // Stage 2: the first sample seen in IDLE is handled as a FOLLOW sample.
    always_comb begin
        state_n    = state;
        prev_err_n = prev_err;
        dark_n     = dark_cnt;
        bright_n   = bright_cnt;
        speed_l_n  = speed_l;
        speed_r_n  = speed_r;
        dir_l_n    = dir_l;
        dir_r_n    = dir_r;
        pulse_n    = 1'b0;
        lost_n     = lost;
        node_cnt_n = node_cnt;
        cur        = (state == ST_IDLE) ? ST_FOLLOW : state;
        if (s1_vld) begin
            if (s1_dark) begin
                if (dark_cnt != NODE_C) begin
                    dark_n = dark_cnt + DW'(1);
                    if (dark_cnt == NODE_C - DW'(1)) begin
                        pulse_n    = 1'b1;
                        node_cnt_n = node_cnt + 8'd1;
                    end
                end
            end else begin
                dark_n = '0;
            end

            if (s1_bright) begin
                bright_n = (bright_cnt == TMO_C) ? bright_cnt : bright_cnt + BW'(1);
                if (bright_n == TMO_C) begin
                    state_n   = ST_STOP;
                    speed_l_n = '0;
                    speed_r_n = '0;
                    dir_l_n   = 1'b1;
                    dir_r_n   = 1'b1;
                    lost_n    = 1'b1;
                end else begin
                    state_n   = ST_LOST;
                    speed_l_n = BASE_C;
                    speed_r_n = BASE_C;
                    dir_l_n   = 1'b1;
                    dir_r_n   = 1'b0;
                    lost_n    = 1'b0;
                end
            end else begin
                state_n   = ST_FOLLOW;
                bright_n  = '0;
                lost_n    = 1'b0;
                dir_l_n   = 1'b1;
                dir_r_n   = 1'b1;
                speed_l_n = BASE_C;
                speed_r_n = BASE_C;
                if (cur == ST_FOLLOW) begin
                    prev_err_n = s1_err;
                    if (dark_n == '0) begin
                        speed_l_n = pd_l;
                        speed_r_n = pd_r;
                    end
                end else begin
                    prev_err_n = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            prev_err   <= '0;
            dark_cnt   <= '0;
            bright_cnt <= '0;
            speed_l    <= '0;
            speed_r    <= '0;
            dir_l      <= 1'b1;
            dir_r      <= 1'b1;
            node_pulse <= 1'b0;
            lost       <= 1'b0;
            node_cnt   <= '0;
        end else if (!en) begin
            state      <= ST_IDLE;
            prev_err   <= '0;
            dark_cnt   <= '0;
            bright_cnt <= '0;
            speed_l    <= '0;
            speed_r    <= '0;
            dir_l      <= 1'b1;
            dir_r      <= 1'b1;
            node_pulse <= 1'b0;
            lost       <= 1'b0;
        end else begin
            state      <= state_n;
            prev_err   <= prev_err_n;
            dark_cnt   <= dark_n;
            bright_cnt <= bright_n;
            speed_l    <= speed_l_n;
            speed_r    <= speed_r_n;
            dir_l      <= dir_l_n;
            dir_r      <= dir_r_n;
            node_pulse <= pulse_n;
            lost       <= lost_n;
            node_cnt   <= node_cnt_n;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_line_follower_pd.sv
// Scoreboard bench for line_follower_pd: reference model pushes expectations, monitor pops at output time.
module tb_line_follower_pd;

    localparam int NCH   = 3;
    localparam int ADC_W = 12;
    localparam int SPD_W = 14;
    localparam int BASE  = 11000;
    localparam int MAXS  = 16383;
    localparam int DTH   = 1600;
    localparam int BTH   = 600;
    localparam int KP    = 0;
    localparam int KD    = 0;
    localparam int NODES = 4;
    localparam int TMO   = 50;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 en = 1'b0;
    logic                 adc_valid = 1'b0;
    logic [NCH*ADC_W-1:0] adc_data = '0;
    logic [SPD_W-1:0]     speed_l, speed_r;
    logic                 dir_l, dir_r, node_pulse, lost;
    logic [7:0]           node_cnt;
    logic [1:0]           state_o;

    always #5 clk = ~clk;

    line_follower_pd dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .speed_l    (speed_l),
        .dir_l      (dir_l),
        .speed_r    (speed_r),
        .dir_r      (dir_r),
        .node_pulse (node_pulse),
        .node_cnt   (node_cnt),
        .lost       (lost),
        .state_o    (state_o)
    );

    typedef struct {
        int sl; int dl; int sr; int dr; int np; int nc; int lo; int st;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int checks = 0;
    int errors = 0;

    // Reference model state: 0 idle, 1 follow, 2 lost, 3 stop.
    int m_state = 0, m_prev = 0, m_dark = 0, m_bright = 0, m_node = 0;

    task automatic chk(input string nm, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, expv);
        end
    endtask

    function automatic int clampv(input int v);
        if (v < 0) return 0;
        if (v > MAXS) return MAXS;
        return v;
    endfunction

    task automatic model_sample(input int c0, input int c1, input int c2);
        int ch[NCH];
        int err, st, p, d;
        bit dark, bright;
        exp_t x;
        ch[0] = c0; ch[1] = c1; ch[2] = c2;
        err = 0; dark = 1; bright = 1;
        for (int i = 0; i < NCH; i++) begin
            if (i < NCH/2) err += ch[i];
            if (i >= NCH - NCH/2) err -= ch[i];
            if (!(ch[i] > DTH)) dark = 0;
            if (!(ch[i] < BTH)) bright = 0;
        end
        st = (m_state == 0) ? 1 : m_state;
        x.np = 0;
        if (dark) begin
            if (m_dark < NODES) begin
                m_dark++;
                if (m_dark == NODES) begin
                    x.np = 1;
                    m_node = (m_node + 1) % 256;
                end
            end
        end else begin
            m_dark = 0;
        end
        if (bright) begin
            if (m_bright < TMO) m_bright++;
            if (m_bright >= TMO) begin
                m_state = 3; x.sl = 0; x.sr = 0; x.dl = 1; x.dr = 1; x.lo = 1;
            end else begin
                m_state = 2; x.sl = BASE; x.sr = BASE; x.dl = 1; x.dr = 0; x.lo = 0;
            end
        end else begin
            m_bright = 0; m_state = 1; x.dl = 1; x.dr = 1; x.lo = 0;
            x.sl = BASE; x.sr = BASE;
            if (st == 1) begin
                if (m_dark == 0) begin
                    p = err >>> KP;
                    d = (err - m_prev) >>> KD;
                    x.sl = clampv(BASE - p - d);
                    x.sr = clampv(BASE + p + d);
                end
                m_prev = err;
            end else begin
                m_prev = 0;
            end
        end
        x.nc = m_node;
        x.st = m_state;
        q.push_back(x);
    endtask

    task automatic model_disable();
        m_state = 0; m_prev = 0; m_dark = 0; m_bright = 0;
    endtask

    task automatic send(input int c0, input int c1, input int c2);
        adc_data  = {ADC_W'(c2), ADC_W'(c1), ADC_W'(c0)};
        adc_valid = 1'b1;
        model_sample(c0, c1, c2);
        @(posedge clk); #1;
        adc_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input int nc);
        chk({tag, "_state"}, int'(state_o), 0);
        chk({tag, "_speed_l"}, int'(speed_l), 0);
        chk({tag, "_speed_r"}, int'(speed_r), 0);
        chk({tag, "_dir_l"}, int'(dir_l), 1);
        chk({tag, "_dir_r"}, int'(dir_r), 1);
        chk({tag, "_lost"}, int'(lost), 0);
        chk({tag, "_pulse"}, int'(node_pulse), 0);
        chk({tag, "_node_cnt"}, int'(node_cnt), nc);
    endtask

    function automatic int rnd_ch(input int cat);
        case (cat)
            0:       return int'($urandom_range(1601, 4095));
            1:       return int'($urandom_range(0, 599));
            2:       return int'($urandom_range(0, 4095));
            default: return int'($urandom_range(700, 1500));
        endcase
    endfunction

    // Output-time tracker: a sample accepted at edge N is presented after edge N+1.
    logic v_d1 = 1'b0, v_d2 = 1'b0;
    always @(posedge clk) begin
        v_d1 <= adc_valid && en && rst;
        v_d2 <= v_d1 && en && rst;
    end

    always @(negedge clk) begin
        if (v_d2) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got output with empty scoreboard, required none");
            end else begin
                e = q.pop_front();
                chk("speed_l", int'(speed_l), e.sl);
                chk("dir_l", int'(dir_l), e.dl);
                chk("speed_r", int'(speed_r), e.sr);
                chk("dir_r", int'(dir_r), e.dr);
                chk("node_pulse", int'(node_pulse), e.np);
                chk("node_cnt", int'(node_cnt), e.nc);
                chk("lost", int'(lost), e.lo);
                chk("state_o", int'(state_o), e.st);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cat;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset", 0);
        rst = 1'b1;
        en  = 1'b1;
        @(posedge clk); #1;

        send(800, 1200, 800);
        drain();
        chk("centred_speed_l", int'(speed_l), 11000);
        send(1000, 1000, 700);
        send(1000, 1000, 700);
        send(800, 1200, 800);
        send(4095, 1000, 0);
        drain();
        chk("sat_speed_l", int'(speed_l), 2810);
        chk("sat_speed_r", int'(speed_r), 16383);

        repeat (3) send(2000, 2000, 2000);
        send(1000, 1000, 300);
        repeat (5) send(2000, 2000, 2000);
        send(1000, 1000, 300);
        drain();
        chk("node_count_one", int'(node_cnt), 1);

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_disable();
        m_node = 0;
        check_idle("midrst", 0);
        rst = 1'b1;

        repeat (256) begin
            repeat (4) send(2000, 2000, 2000);
            send(1000, 1000, 300);
        end
        drain();
        chk("node_wrap", int'(node_cnt), 0);

        repeat (TMO) send(100, 100, 100);
        drain();
        chk("stop_state", int'(state_o), 3);
        chk("stop_lost", int'(lost), 1);
        send(1000, 1000, 300);
        send(100, 100, 100);
        drain();
        chk("lost_state", int'(state_o), 2);
        en = 1'b0;
        @(posedge clk); #1;
        model_disable();
        check_idle("en_off", m_node);
        en = 1'b1;
        @(posedge clk); #1;

        for (int n = 0; n < 400; n++) begin
            cat = int'($urandom_range(0, 4));
            if (cat == 4) begin
                send(rnd_ch(2), rnd_ch(2), rnd_ch(2));
            end else if (cat == 1 && $urandom_range(0, 9) == 0) begin
                repeat (TMO) send(rnd_ch(1), rnd_ch(1), rnd_ch(1));
            end else begin
                send(rnd_ch(cat), rnd_ch(cat), rnd_ch(cat));
            end
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk); #1;
                end
            end
        end
        drain();
        chk("scoreboard_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
